// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit type, digit bounds, countdown FSM states and
// a digit validity helper.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cd_state_t;

  // True when a nibble holds a legal decimal digit.
  function automatic logic is_bcd_digit(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/decade_down_digit.sv
// One BCD decade of the countdown chain: loads a digit, decrements on dec and
// wraps from 0 to 9 so the next decade up sees the borrow.
module decade_down_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] d,
  input  logic       dec,
  output logic [3:0] q,
  output logic       is_zero
);

  // Digit register: reset > load > decrement with 0 -> 9 wrap.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // is not in the sensitivity list; <= keeps every flop updating from
    // pre-edge values regardless of statement order.
    if (!reset) begin
      q <= BCD_MIN;
    end else if (load) begin
      q <= d;
    end else if (dec) begin
      q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
    end
  end

  assign is_zero = (q == BCD_MIN);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer. Digits are chained so each decrements only
// when the ones below it are all zero; the top level owns the IDLE/RUN FSM,
// the done/err pulses and, with COUNTDOWN_AUTORELOAD_EN defined, the reload
// register that restarts the count after it reaches zero.
module bcd_countdown_timer
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                stop,
  input  logic                tick,
  output logic [4*DIGITS-1:0] count,
  output logic                running,
  output logic                zero,
  output logic                done,
  output logic                err
);

  cd_state_t           state;
  logic [DIGITS-1:0]   dig_zero;
  logic [DIGITS-1:0]   dig_dec;
  logic [4*DIGITS-1:0] dig_d;
  logic                dig_load;
  logic                load_ok;
  logic                upper_zero;
  logic                count_one;
  logic                do_tick;
  logic                do_dec;
  logic                reload_fire;

  // Validity of the requested load and "count == 1" detection.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    load_ok    = 1'b1;
    upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      load_ok = load_ok & is_bcd_digit(load_val[4*i +: 4]);
    end
    for (int i = 1; i < DIGITS; i++) begin
      upper_zero = upper_zero & dig_zero[i];
    end
  end

  assign count_one = (count[3:0] == 4'd1) && upper_zero;
  assign zero      = &dig_zero;
  assign running   = (state == RUN);

  // A tick only acts in RUN and when neither load nor stop claims the cycle.
  assign do_tick = tick && (state == RUN) && !load && !stop;
  assign do_dec  = do_tick && !zero;

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [4*DIGITS-1:0] reload_reg;

  // Reload register follows every accepted load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      reload_reg <= '0;
    end else if (load && load_ok) begin
      reload_reg <= load_val;
    end
  end

  // Zero count while still running means the period ended: restart it.
  assign reload_fire = do_tick && zero;
  assign dig_d       = load ? load_val : reload_reg;
`else
  assign reload_fire = 1'b0;
  assign dig_d       = load_val;
`endif

  assign dig_load = (load && load_ok) || reload_fire;

  // Borrow chain: digit i steps only when all lower digits are zero.
  assign dig_dec[0] = do_dec;
  for (genvar i = 1; i < DIGITS; i++) begin : g_chain
    assign dig_dec[i] = dig_dec[i-1] && dig_zero[i-1];
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    decade_down_digit u_digit (
      .clk     (clk),
      .reset   (reset),
      .load    (dig_load),
      .d       (dig_d[4*i +: 4]),
      .dec     (dig_dec[i]),
      .q       (count[4*i +: 4]),
      .is_zero (dig_zero[i])
    );
  end

  // Control FSM and one-cycle done/err pulses, priority load > stop > start > tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (load) begin
        if (load_ok) begin
          state <= IDLE;
        end else begin
          err <= 1'b1;
        end
      end else if (stop) begin
        state <= IDLE;
      end else if (start && (state == IDLE)) begin
        if (!zero) begin
          state <= RUN;
        end
      end else if (do_tick && count_one) begin
        done <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
        if (reload_reg == '0) begin
          state <= IDLE;
        end
`else
        state <= IDLE;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed self-checking bench for bcd_countdown_timer (DIGITS = 4).
// Expectations follow the default build; COUNTDOWN_AUTORELOAD_EN selects the
// reload-variant expectations in the terminal-count section.
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] load_val;
  logic        start;
  logic        stop;
  logic        tick;
  logic [15:0] count;
  logic        running;
  logic        zero;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.DIGITS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .tick     (tick),
    .count    (count),
    .running  (running),
    .zero     (zero),
    .done     (done),
    .err      (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load     = 1'b1;
    load_val = v;
    cycle();
    load     = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; load_val = '0;
    start = 1'b0; stop = 1'b0; tick = 1'b0;

    // Reset held for two cycles.
    cycle(); cycle();
    check("rst_count",   count,   16'h0000);
    check("rst_zero",    zero,    1'b1);
    check("rst_running", running, 1'b0);
    check("rst_done",    done,    1'b0);
    check("rst_err",     err,     1'b0);
    reset = 1'b1;

    // 0102 counts down through a two-digit borrow.
    do_load(16'h0102);
    check("ld102_count",   count,   16'h0102);
    check("ld102_running", running, 1'b0);
    do_start();
    check("st102_running", running, 1'b1);
    tick = 1'b1;
    cycle(); check("dec_0101", count, 16'h0101);
    cycle(); check("dec_0100", count, 16'h0100);
    cycle(); check("dec_0099", count, 16'h0099);
    check("dec_0099_zero", zero, 1'b0);
    tick = 1'b0;

    // Borrow across all upper digits.
    do_load(16'h1000);
    check("ld1000_running", running, 1'b0);
    do_start();
    tick = 1'b1;
    cycle(); check("dec_0999", count, 16'h0999);
    tick = 1'b0;

    // Terminal count from 0002.
    do_load(16'h0002);
    do_start();
    tick = 1'b1;
    cycle();
    check("tc_0001",      count, 16'h0001);
    check("tc_0001_done", done,  1'b0);
    cycle();
    check("tc_0000",      count, 16'h0000);
    check("tc_done",      done,  1'b1);
    check("tc_zero",      zero,  1'b1);
`ifdef COUNTDOWN_AUTORELOAD_EN
    check("tc_running", running, 1'b1);
    cycle();
    check("reload_count",   count,   16'h0002);
    check("reload_running", running, 1'b1);
    check("reload_done",    done,    1'b0);
    tick = 1'b0;
    stop = 1'b1; cycle(); stop = 1'b0;
    check("reload_stop", running, 1'b0);
`else
    check("tc_running", running, 1'b0);
    cycle();
    check("tc_hold_count", count, 16'h0000);
    check("tc_done_pulse", done,  1'b0);
    tick = 1'b0;
`endif

    // Rejected load leaves count alone; start at zero is ignored.
    do_load(16'h0000);
    check("ld0_zero", zero, 1'b1);
    do_load(16'h00A3);
    check("bad_err",   err,   1'b1);
    check("bad_count", count, 16'h0000);
    cycle();
    check("bad_err_clr", err, 1'b0);
    do_start();
    check("st0_running", running, 1'b0);
    check("st0_done",    done,    1'b0);

    // Stop beats tick.
    do_load(16'h0050);
    do_start();
    stop = 1'b1; tick = 1'b1;
    cycle();
    stop = 1'b0; tick = 1'b0;
    check("stop_count",   count,   16'h0050);
    check("stop_running", running, 1'b0);

    // Load beats tick and aborts the run.
    do_start();
    check("rs_running", running, 1'b1);
    load = 1'b1; load_val = 16'h0007; tick = 1'b1;
    cycle();
    load = 1'b0; tick = 1'b0;
    check("ldtick_count",   count,   16'h0007);
    check("ldtick_running", running, 1'b0);

    // Stop beats the terminal tick: no done.
    do_load(16'h0001);
    do_start();
    stop = 1'b1; tick = 1'b1;
    cycle();
    stop = 1'b0; tick = 1'b0;
    check("stoptc_count", count, 16'h0001);
    check("stoptc_done",  done,  1'b0);

    // Mid-run reset during a tick.
    do_load(16'h0020);
    do_start();
    tick = 1'b1;
    cycle();
    check("mr_0019", count, 16'h0019);
    reset = 1'b0;
    cycle();
    reset = 1'b1; tick = 1'b0;
    check("mr_count",   count,   16'h0000);
    check("mr_done",    done,    1'b0);
    check("mr_running", running, 1'b0);
    check("mr_zero",    zero,    1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Multi-digit BCD down-counter that counts from a loaded decimal value to zero, one decade digit per nibble with borrow rippling between digits. It is the down-counting counterpart of the team's 0–9 up-counting decade counter. It sits between a prescaler, which supplies `tick`, and the display or control logic that consumes `count` and `done`.

## Interface
- `DIGITS`, default 4: number of BCD digits; legal range 1–8.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-low reset; sampled on the `clk` rising edge.
- `load` input 1: one-cycle request to load `load_val`.
- `load_val` input 4*DIGITS: BCD value to load; nibble 0 is the least significant digit.
- `start` input 1: begin or resume counting.
- `stop` input 1: pause counting.
- `tick` input 1: count-enable strobe; one decrement per cycle in which it is high.
- `count` output 4*DIGITS: current BCD value, registered.
- `running` output 1: high while in the RUN state.
- `zero` output 1: high when `count` equals 0.
- `done` output 1: one-cycle pulse when counting reaches 0.
- `err` output 1: one-cycle pulse when a load is rejected.

## Operation
- **States:** IDLE and RUN.
- **Reset:** while `reset` is low at a clock edge, all of the following are forced:
  - state = IDLE, `count` = 0, reload register = 0;
  - `running` = 0, `zero` = 1, `done` = 0, `err` = 0.
  - Reset overrides every other input, including in the middle of a count.
- **Priority per cycle:** `load` > `stop` > `start` > `tick`.
- **load:**
  - Any nibble of `load_val` above 9: the load is rejected. `err` = 1 for one cycle, and `count`, state and reload register are unchanged.
  - Otherwise: `count` and the reload register take `load_val`, and the state goes to IDLE (aborts any run).
- **stop:** RUN goes to IDLE; `count` is held. In IDLE it has no effect.
- **start:**
  - IDLE goes to RUN only when `count` is nonzero.
  - With `count` = 0 it is ignored: no state change, no `done`.
  - In RUN it has no effect.
- **tick in RUN:** `count` is decremented by 1 in BCD.
  - Digit i decrements only when `tick` is high and all lower digits are 0.
  - A digit at 0 that decrements wraps to 9 (borrow).
- **tick in IDLE:** ignored.
- **Terminal count:** a tick with `count` = 1 drives `count` to 0 and pulses `done` in the same cycle `count` shows 0. The state after that depends on COUNTDOWN_AUTORELOAD_EN (see Configuration).
- **zero:** registered, consistent with `count` in every cycle.

## Timing
- One-cycle latency: inputs sampled at edge N are reflected on all outputs after edge N.
- `done` and `err` are high for exactly one cycle, then return to 0.
- `tick` on consecutive cycles gives consecutive decrements; there is no throughput limit.
- Load and tick in the same cycle: the load wins and no decrement occurs.
- Stop and the terminal tick in the same cycle: the stop wins, `count` stays at 1, no `done`.

## Configuration
- **COUNTDOWN_AUTORELOAD_EN defined:**
  - At terminal count, `count` reloads from the reload register on the next tick instead of decrementing 0 to 9.
  - The state stays RUN and `done` pulses once per period.
  - If the reload register is 0, the state goes to IDLE.
- **COUNTDOWN_AUTORELOAD_EN undefined:**
  - At terminal count the state goes to IDLE and `count` holds at 0.
  - The reload register is not instantiated; `count` alone is the load target.

## Structure
- Shared package `bcd_pkg`:
  - `bcd_digit_t` (4-bit);
  - `BCD_MAX` = 9, `BCD_MIN` = 0;
  - state enum `cd_state_t` {IDLE, RUN}.
- One sub-module, `decade_down_digit`, used once per digit:
  - ports: `clk`, `reset`, `load`, `d`, `dec`;
  - outputs: `q`, `is_zero`;
  - it wraps 0 to 9 on `dec`.
- The top level chains the `dec` enables and holds the FSM, the flags and the reload register.

## Test plan
- Reset with `reset` = 0 for 2 cycles → `count` = 0000, `zero` = 1, `running` = 0, `done` = 0, `err` = 0.
- DIGITS = 4, load 0x0102, start, 3 ticks → `count` sequence 0101, 0100, 0099.
- Load 0x0002, start, 2 ticks → `count` 0001 then 0000 with `done` = 1 for one cycle.
  - Without the macro: `running` = 0.
  - With the macro: the next tick gives 0002 and `running` = 1.
- Load 0x00A3 → `err` pulses once, `count` unchanged. Then start with `count` = 0 → `running` stays 0.
- Running 0x0050: stop and tick in the same cycle → `count` holds 0050. Load 0x0007 together with a tick → `count` = 0007, state IDLE.
- Mid-run `reset` low for one cycle during tick → `count` = 0000 next cycle; `done` not asserted.
